toggle_sync_rx: RTL and testbench
=================================

# toggle_sync_rx

Receive end of the toggle-handshake clock-domain crossing. It lives entirely in the clk_b domain and accepts a request toggle plus a quasi-static data word from a sender in another clock domain. It synchronizes the toggle, captures the word, presents it to a local consumer with a valid/ready handshake, and returns an acknowledge toggle to the sender once the consumer has taken the word. This block pairs with the toggle_sync sender-side logic, which flips the request only after it has seen the previous acknowledge.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (at least 1).
- SYNC_STAGES, 2, flops in the request synchronizer chain (at least 2).

Ports:
- clk_b  in  1  receive-domain clock; all state is clocked on the rising edge.
- rst_b_n  in  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
- req_tog_a  in  1  request toggle from the sender domain, asynchronous to clk_b; each transition means one new word.
- data_a  in  WIDTH  sender data; must be stable from before the req_tog_a transition until ack_tog_b returns.
- data_b  out  WIDTH  captured word; reset 0.
- valid_b  out  1  data_b holds an unconsumed word; reset 0.
- ready_b  in  1  consumer accepts data_b when valid_b && ready_b.
- pulse_b  out  1  one-cycle strobe on each accepted request; reset 0.
- ack_tog_b  out  1  acknowledge toggle to the sender; reset 0.
- ovr_b  out  1  sticky overrun flag; reset 0. Present only with TOGGLE_RX_OVR_EN.

## Operation
- Synchronizer: sync[0..SYNC_STAGES-1] shifts req_tog_a; all stages reset to 0. Only sync[last] feeds logic.
- req_seen register: reset 0. edge = sync[last] ^ req_seen.
- State IDLE (reset state):
  - If edge is 1: load data_b <= data_a, set valid_b <= 1, pulse_b <= 1, req_seen <= sync[last], then go to HOLD.
  - Otherwise: outputs hold, and pulse_b <= 0.
- State HOLD:
  - pulse_b <= 0.
  - On valid_b && ready_b: valid_b <= 0, ack_tog_b <= ~ack_tog_b, then go to IDLE.
  - data_b holds its value while valid_b = 1.
- An edge arising in HOLD is not consumed: req_seen is not updated, so the edge is serviced in IDLE after the current word is acknowledged. No request is dropped.
- Invalid state encoding recovers to IDLE with valid_b = 0.
- Reset mid-transfer clears the state to IDLE and all outputs to 0. The system resets sender and receiver together, so req_tog_a = 0 while rst_b_n is low.

## Timing
- Request latency: if req_tog_a changes and meets setup before rising edge 1, then sync[last] changes at edge SYNC_STAGES, and valid_b, pulse_b and data_b change at edge SYNC_STAGES+1. With the default, that is 3 edges.
- pulse_b is high for exactly one cycle, aligned with the first cycle of valid_b.
- Accept: if ready_b is high in the cycle valid_b rises, the word is accepted at the next edge. valid_b is then high for a minimum of 1 cycle.
- ack_tog_b changes at the same edge that clears valid_b. The earliest next capture is SYNC_STAGES+1 edges after the next req_tog_a change.
- Throughput limit: one word per full round trip (sender sync, then receiver sync). The block itself adds 1 cycle in IDLE and at least 1 cycle in HOLD.

## Configuration
- TOGGLE_RX_OVR_EN defined:
  - ovr_b exists. It sets to 1 at the edge where edge = 1 while in HOLD and sync[last] differs from the value previously latched as the pending edge.
  - This means a second request toggle arrived before the acknowledge, which is a protocol violation by the sender.
  - ovr_b stays set until rst_b_n.
- TOGGLE_RX_OVR_EN undefined: ovr_b port and logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset and idle: hold rst_b_n = 0 for 3 cycles with req_tog_a = 0, then release. Required: data_b = 0, valid_b = 0, pulse_b = 0, ack_tog_b = 0, ovr_b = 0, and nothing changes for 10 cycles.
- Single transfer: set data_a = 8'hA5, toggle req_tog_a 0→1, ready_b = 1. Required: valid_b and pulse_b high at clk_b edge 3 with data_b = A5; pulse_b low after 1 cycle; valid_b low and ack_tog_b = 1 at edge 4.
- Backpressure: ready_b = 0 for 5 cycles after valid_b rises. Required: data_b holds its value, valid_b stays 1, ack_tog_b is unchanged; one edge after ready_b = 1, valid_b = 0 and ack_tog_b toggles.
- Back-to-back handshakes: sender model toggles a new word (01, 02, 03) after each ack_tog_b flip. Required: three pulse_b strobes, data_b sequence 01, 02, 03, ack_tog_b ends at 1.
- Overrun (macro on): toggle req_tog_a twice while ready_b = 0. Required: ovr_b = 1, first word retained, second request served after the ack; with the macro off, the same stimulus produces the same data with no ovr_b port.
- Reset mid-HOLD: assert rst_b_n with valid_b = 1. Required: valid_b, data_b and ack_tog_b become 0 immediately without waiting for a clock edge, and the block is in IDLE after release.

Source files
------------

// File: rtl/toggle_sync_rx.sv
`default_nettype none
// ============================================================================
// Module   : toggle_sync_rx
// Brief    : Receive end of a toggle-handshake CDC. Synchronizes the request
//            toggle, captures the sender word, offers it on valid/ready and
//            returns an acknowledge toggle once the word is consumed.
//            Optional sticky overrun flag ovr_b when TOGGLE_RX_OVR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_sync_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_b,
    input  logic             rst_b_n,
    input  logic             req_tog_a,
    input  logic [WIDTH-1:0] data_a,
    output logic [WIDTH-1:0] data_b,
    output logic             valid_b,
    input  logic             ready_b,
    output logic             pulse_b,
    output logic             ack_tog_b
`ifdef TOGGLE_RX_OVR_EN
    ,
    output logic             ovr_b
`endif
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HOLD = 2'd1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req_seen;
    logic [1:0]             r_state;
    logic [WIDTH-1:0]       r_data;
    logic                   r_valid;
    logic                   r_pulse;
    logic                   r_ack;
    logic                   w_sync_last;
    logic                   w_edge;

    assign w_sync_last = r_sync[SYNC_STAGES-1];
    assign w_edge      = w_sync_last ^ r_req_seen;

    // Only the last stage may feed logic; earlier stages can be metastable.
    always_ff @(posedge clk_b or negedge rst_b_n) begin
        if (!rst_b_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], req_tog_a};
        end
    end

    always_ff @(posedge clk_b or negedge rst_b_n) begin
        if (!rst_b_n) begin
            r_state    <= c_ST_IDLE;
            r_req_seen <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_pulse    <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_edge) begin
                        r_data     <= data_a;
                        r_valid    <= 1'b1;
                        r_pulse    <= 1'b1;
                        r_req_seen <= w_sync_last;
                        r_state    <= c_ST_HOLD;
                    end else begin
                        r_pulse <= 1'b0;
                    end
                end
                c_ST_HOLD: begin
                    // A new edge seen here stays pending and is taken in IDLE.
                    r_pulse <= 1'b0;
                    if (r_valid && ready_b) begin
                        r_valid <= 1'b0;
                        r_ack   <= ~r_ack;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_valid <= 1'b0;
                    r_pulse <= 1'b0;
                end
            endcase
        end
    end

    assign data_b    = r_data;
    assign valid_b   = r_valid;
    assign pulse_b   = r_pulse;
    assign ack_tog_b = r_ack;

`ifdef TOGGLE_RX_OVR_EN
    logic r_ovr;

    // Any edge while a word is still held means the sender toggled before the ack.
    always_ff @(posedge clk_b or negedge rst_b_n) begin
        if (!rst_b_n) begin
            r_ovr <= 1'b0;
        end else if (r_state == c_ST_HOLD && w_edge) begin
            r_ovr <= 1'b1;
        end
    end

    assign ovr_b = r_ovr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_toggle_sync_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_toggle_sync_rx
// Brief    : Self-checking bench for toggle_sync_rx: vector table, directed
//            multi-cycle sequences and a randomized sender with scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_sync_rx;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int c_LAT       = SYNC_STAGES + 1;

    logic             clk_b     = 1'b0;
    logic             rst_b_n   = 1'b0;
    logic             req_tog_a = 1'b0;
    logic [WIDTH-1:0] data_a    = '0;
    logic             ready_b   = 1'b0;
    logic [WIDTH-1:0] data_b;
    logic             valid_b;
    logic             pulse_b;
    logic             ack_tog_b;
`ifdef TOGGLE_RX_OVR_EN
    logic             ovr_b;
`endif

    toggle_sync_rx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dut (
        .clk_b     (clk_b),
        .rst_b_n   (rst_b_n),
        .req_tog_a (req_tog_a),
        .data_a    (data_a),
        .data_b    (data_b),
        .valid_b   (valid_b),
        .ready_b   (ready_b),
        .pulse_b   (pulse_b),
        .ack_tog_b (ack_tog_b)
`ifdef TOGGLE_RX_OVR_EN
        ,
        .ovr_b     (ovr_b)
`endif
    );

    always #5 clk_b = ~clk_b;

    int cyc = 0;
    always @(posedge clk_b) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic             rst_n;
        logic             req;
        logic [WIDTH-1:0] data;
        logic             ready;
        logic             v;
        logic             p;
        logic [WIDTH-1:0] d;
        logic             a;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rn, input logic req, input logic [WIDTH-1:0] d,
                           input logic rdy, input logic v, input logic p,
                           input logic [WIDTH-1:0] dd, input logic a);
        vec_t t;
        t.rst_n = rn; t.req = req; t.data = d; t.ready = rdy;
        t.v = v; t.p = p; t.d = dd; t.a = a;
        vecs.push_back(t);
    endtask

    task automatic reset_dut();
        @(negedge clk_b);
        rst_b_n   = 1'b0;
        req_tog_a = 1'b0;
        ready_b   = 1'b0;
        data_a    = '0;
        repeat (3) @(negedge clk_b);
        rst_b_n = 1'b1;
        @(negedge clk_b);
    endtask

    // Watchdog: the run must always end on its own.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] got[$];
        int               sent;
        bit               pending;
        bit               exp_rise;
        bit               exp_valid;
        bit               exp_accept;
        bit               prev_v;
        logic             exp_ack;
        logic [WIDTH-1:0] sent_word;
        logic [WIDTH-1:0] held;
        int               tog_cyc;
        int               gap;
        int               n_sent;
        int               n_rcvd;

        // ---------------- vector table: reset, idle, single transfer, backpressure
        repeat (3) add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (11) add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        add_vec(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        add_vec(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        add_vec(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0);
        add_vec(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1);
        add_vec(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1);
        add_vec(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1);
        add_vec(1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1);
        repeat (5) add_vec(1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1);
        add_vec(1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_b);
            rst_b_n   = vecs[i].rst_n;
            req_tog_a = vecs[i].req;
            data_a    = vecs[i].data;
            ready_b   = vecs[i].ready;
            @(posedge clk_b);
            #1;
            chk($sformatf("vec%0d valid_b", i), valid_b, vecs[i].v);
            chk($sformatf("vec%0d pulse_b", i), pulse_b, vecs[i].p);
            chk($sformatf("vec%0d data_b", i), data_b, vecs[i].d);
            chk($sformatf("vec%0d ack_tog_b", i), ack_tog_b, vecs[i].a);
`ifdef TOGGLE_RX_OVR_EN
            chk($sformatf("vec%0d ovr_b", i), ovr_b, 1'b0);
`endif
        end

        // ---------------- back-to-back handshakes with an ack-following sender
        reset_dut();
        ready_b = 1'b1;
        sent    = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_b);
            if (pulse_b) got.push_back(data_b);
            if (sent == 3 && ack_tog_b == req_tog_a && got.size() == 3) break;
            if (ack_tog_b == req_tog_a && sent < 3) begin
                sent++;
                data_a    = WIDTH'(sent);
                req_tog_a = ~req_tog_a;
            end
        end
        chk("b2b pulse count", got.size(), 3);
        for (int k = 0; k < 3 && k < got.size(); k++)
            chk($sformatf("b2b word%0d", k), got[k], k + 1);
        chk("b2b final ack", ack_tog_b, 1'b1);
        ready_b = 1'b0;

        // ---------------- overrun: second toggle while the first word is held
        reset_dut();
        data_a    = 8'h11;
        req_tog_a = 1'b1;
        repeat (c_LAT) @(negedge clk_b);
        chk("ovr first valid", valid_b, 1'b1);
        chk("ovr first pulse", pulse_b, 1'b1);
        chk("ovr first data", data_b, 8'h11);
        data_a    = 8'h22;
        req_tog_a = 1'b0;
        repeat (5) @(negedge clk_b);
        chk("ovr held valid", valid_b, 1'b1);
        chk("ovr held data", data_b, 8'h11);
        chk("ovr held ack", ack_tog_b, 1'b0);
`ifdef TOGGLE_RX_OVR_EN
        chk("ovr flag", ovr_b, 1'b1);
`endif
        ready_b = 1'b1;
        @(negedge clk_b);
        chk("ovr accept valid", valid_b, 1'b0);
        chk("ovr accept ack", ack_tog_b, 1'b1);
        ready_b = 1'b0;
        @(negedge clk_b);
        chk("ovr second valid", valid_b, 1'b1);
        chk("ovr second pulse", pulse_b, 1'b1);
        chk("ovr second data", data_b, 8'h22);
        ready_b = 1'b1;
        @(negedge clk_b);
        chk("ovr second accept", valid_b, 1'b0);
        chk("ovr second ack", ack_tog_b, 1'b0);
`ifdef TOGGLE_RX_OVR_EN
        chk("ovr sticky", ovr_b, 1'b1);
`endif
        ready_b = 1'b0;

        // ---------------- reset while a word is held
        data_a    = 8'h5A;
        req_tog_a = 1'b1;
        repeat (c_LAT) @(negedge clk_b);
        ready_b = 1'b1;
        @(negedge clk_b);
        chk("mid pre ack", ack_tog_b, 1'b1);
        ready_b   = 1'b0;
        data_a    = 8'hC3;
        req_tog_a = 1'b0;
        repeat (c_LAT) @(negedge clk_b);
        chk("mid hold valid", valid_b, 1'b1);
        chk("mid hold data", data_b, 8'hC3);
        #2;
        rst_b_n = 1'b0;
        #1;
        chk("mid async valid", valid_b, 1'b0);
        chk("mid async data", data_b, 8'h00);
        chk("mid async ack", ack_tog_b, 1'b0);
        chk("mid async pulse", pulse_b, 1'b0);
`ifdef TOGGLE_RX_OVR_EN
        chk("mid async ovr", ovr_b, 1'b0);
`endif
        @(negedge clk_b);
        rst_b_n = 1'b1;
        repeat (4) @(negedge clk_b);
        chk("mid idle valid", valid_b, 1'b0);
        chk("mid idle pulse", pulse_b, 1'b0);
        chk("mid idle ack", ack_tog_b, 1'b0);

        // ---------------- randomized sender / consumer against a scoreboard
        reset_dut();
        pending    = 1'b0;
        exp_accept = 1'b0;
        prev_v     = 1'b0;
        exp_ack    = 1'b0;
        held       = '0;
        sent_word  = '0;
        tog_cyc    = 0;
        gap        = 0;
        n_sent     = 0;
        n_rcvd     = 0;
        for (int k = 0; k < 3000 && n_rcvd < 40; k++) begin
            @(negedge clk_b);
            exp_rise  = pending && (cyc == tog_cyc + c_LAT);
            exp_valid = exp_rise || (prev_v && !exp_accept);
            chk("rnd pulse_b", pulse_b, exp_rise);
            chk("rnd valid_b", valid_b, exp_valid);
            chk("rnd ack_tog_b", ack_tog_b, exp_ack);
            if (exp_rise) begin
                chk("rnd captured word", data_b, sent_word);
                held    = sent_word;
                pending = 1'b0;
            end else if (exp_valid) begin
                chk("rnd held word", data_b, held);
            end
            prev_v = exp_valid;

            if (exp_ack == req_tog_a && !pending && !exp_valid && n_sent < 40) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    sent_word = WIDTH'($urandom);
                    data_a    = sent_word;
                    req_tog_a = ~req_tog_a;
                    pending   = 1'b1;
                    tog_cyc   = cyc;
                    n_sent++;
                    gap = $urandom_range(0, 3);
                end
            end

            ready_b    = 1'($urandom_range(0, 1));
            exp_accept = prev_v && ready_b;
            if (exp_accept) begin
                exp_ack = ~exp_ack;
                n_rcvd++;
            end
        end
        chk("rnd words delivered", n_rcvd, 40);
        ready_b = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
